// File: rtl/tft_line_fetch_ctrl.sv
// rtl/tft_line_fetch_ctrl.sv - line-prefetch scheduler filling a ping-pong line buffer pair
// Issues fixed-length framebuffer bursts ahead of scanout and tracks buffer fullness.
module tft_line_fetch_ctrl #(
  parameter int LINES           = 1024,
  parameter int BURSTS_PER_LINE = 20,
  parameter int BURST_WORDS     = 64,
  parameter int BURST_BYTES     = 256
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
  input  logic        Frame_start,
  input  logic        Line_done,
  input  logic [31:0] Fb_base,
  output logic        Rd_req,
  output logic [31:0] Rd_addr,
  output logic [7:0]  Rd_len,
  input  logic        Rd_ack,
  input  logic        Rd_done,
  output logic        Fill_sel,
  output logic        Disp_sel,
  output logic        Line_ready,
  output logic        Frame_busy,
  output logic        Underflow
);

  localparam logic [4:0]  LAST_BURST = 5'(BURSTS_PER_LINE - 1);
  localparam logic [10:0] LAST_LINE  = 11'(LINES - 1);
  localparam logic [31:0] ADDR_STEP  = 32'(BURST_BYTES);
  localparam logic [7:0]  LEN        = 8'(BURST_WORDS);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_DONE, HOLD, DONE} state_t;

  state_t      state;
  logic [10:0] line_cnt;
  logic [4:0]  burst_cnt;
  logic [1:0]  full;
  logic        restart_pend;

  logic        ld_active;
  logic        uf_set;
  logic        burst_end;
  logic        line_end;
  logic        start_now;
  logic        disp_n;
  logic        fill_n;
  logic [1:0]  full_n;

  always_comb begin
    ld_active = Enable && Line_done && (state != IDLE);
    burst_end = Enable && (state == WAIT_DONE) && Rd_done && !restart_pend && !Frame_start;
    line_end  = burst_end && (burst_cnt == LAST_BURST);
    // A pending restart in WAIT_DONE waits for the outstanding burst to finish.
    start_now = Enable && ((((state == IDLE) || (state == DONE)) && Frame_start) ||
                           (((state == REQ) || (state == HOLD)) && restart_pend) ||
                           ((state == WAIT_DONE) && Rd_done && (restart_pend || Frame_start)));
    full_n = full;
    disp_n = Disp_sel;
    fill_n = Fill_sel;
    uf_set = 1'b0;
    if (ld_active) begin
      if (full[Disp_sel]) full_n[Disp_sel] = 1'b0;
      else                uf_set = 1'b1;
      disp_n = ~Disp_sel;
    end
    if (line_end) begin
      full_n[Fill_sel] = 1'b1;
      fill_n = ~Fill_sel;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      line_cnt     <= '0;
      burst_cnt    <= '0;
      full         <= '0;
      restart_pend <= 1'b0;
      Rd_req       <= 1'b0;
      Rd_addr      <= '0;
      Fill_sel     <= 1'b0;
      Disp_sel     <= 1'b0;
      Line_ready   <= 1'b0;
      Frame_busy   <= 1'b0;
      Underflow    <= 1'b0;
    end else if (!Enable) begin
      state        <= IDLE;
      restart_pend <= 1'b0;
      Rd_req       <= 1'b0;
      Frame_busy   <= 1'b0;
      Underflow    <= 1'b0;
    end else if (start_now) begin
      state        <= REQ;
      line_cnt     <= '0;
      burst_cnt    <= '0;
      full         <= '0;
      restart_pend <= 1'b0;
      Rd_req       <= 1'b1;
      Rd_addr      <= Fb_base;
      Fill_sel     <= 1'b0;
      Disp_sel     <= 1'b0;
      Line_ready   <= 1'b0;
      Frame_busy   <= 1'b1;
      if (uf_set) Underflow <= 1'b1;
    end else begin
      full       <= full_n;
      Fill_sel   <= fill_n;
      Disp_sel   <= disp_n;
      Line_ready <= full_n[disp_n];
      if (uf_set) Underflow <= 1'b1;
      case (state)
        REQ: begin
          if (Rd_ack) begin
            state  <= WAIT_DONE;
            Rd_req <= 1'b0;
            if (Frame_start) restart_pend <= 1'b1;
          end else if (Frame_start) begin
            restart_pend <= 1'b1;
            Rd_req       <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (burst_end) begin
            Rd_addr <= Rd_addr + ADDR_STEP;
            if (!line_end) begin
              burst_cnt <= burst_cnt + 5'd1;
              state     <= REQ;
              Rd_req    <= 1'b1;
            end else begin
              burst_cnt <= '0;
              line_cnt  <= line_cnt + 11'd1;
              if (line_cnt == LAST_LINE) begin
                state      <= DONE;
                Frame_busy <= 1'b0;
              end else if (full_n[fill_n]) begin
                state <= HOLD;
              end else begin
                state  <= REQ;
                Rd_req <= 1'b1;
              end
            end
          end else if (Frame_start) begin
            restart_pend <= 1'b1;
          end
        end
        HOLD: begin
          if (Frame_start) begin
            restart_pend <= 1'b1;
          end else if (!full[Fill_sel]) begin
            state  <= REQ;
            Rd_req <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) Rd_len <= LEN;
    else     Rd_len <= LEN;
  end

endmodule

// File: doc/tft_line_fetch_ctrl.md
# tft_line_fetch_ctrl

Line-prefetch scheduler for the TFT display path at 1280x1024. It starts a frame on a one-cycle frame-start pulse from the vertical timing logic, then issues fixed-length burst reads to the framebuffer memory port, filling a ping-pong pair of line buffers ahead of the scanout. It tracks which buffer half holds a complete line and flags underflow when scanout consumes a line that is not ready.

## Interface
Parameters:
- LINES, 1024, displayed lines per frame
- BURSTS_PER_LINE, 20, bursts per line (1280 px x 32 bpp / 64 words)
- BURST_WORDS, 64, 32-bit words per burst; also the constant Rd_len value
- BURST_BYTES, 256, address increment per burst (BURST_WORDS x 4)

Ports:
- Clk  in  1  system clock; the block's only clock
- Rst  in  1  asynchronous, active-high reset
- Enable  in  1  level; 0 forces IDLE and clears Underflow
- Frame_start  in  1  one-cycle pulse at the start of vertical back porch
- Line_done  in  1  one-cycle pulse when scanout finishes a displayed line
- Fb_base  in  32  framebuffer byte base address, sampled on an accepted Frame_start
- Rd_req  out  1  burst read request, held until acked
- Rd_addr  out  32  burst byte address, stable while Rd_req=1
- Rd_len  out  8  constant BURST_WORDS
- Rd_ack  in  1  request accepted this cycle when Rd_req=1
- Rd_done  in  1  one-cycle pulse when the last word of the outstanding burst is written
- Fill_sel  out  1  buffer half being filled by the current burst
- Disp_sel  out  1  buffer half scanout is reading
- Line_ready  out  1  full[Disp_sel]
- Frame_busy  out  1  1 in REQ, WAIT_DONE and HOLD
- Underflow  out  1  sticky underflow flag

## Operation
- All outputs are registered. Reset values: Rd_req=0, Rd_addr=0, Rd_len=BURST_WORDS, Fill_sel=0, Disp_sel=0, Line_ready=0, Frame_busy=0, Underflow=0. State resets to IDLE, full[1:0]=0, and all counters reset to 0.
- States: IDLE, REQ, WAIT_DONE, HOLD, DONE.
- IDLE or DONE, with Enable=1 and Frame_start=1: latch Rd_addr=Fb_base, clear line_cnt (11b), burst_cnt (5b), full[1:0], Fill_sel and Disp_sel, then go to REQ.
- REQ: Rd_req=1. On Rd_ack, go to WAIT_DONE.
- WAIT_DONE: on Rd_done, Rd_addr += BURST_BYTES (mod 2^32).
  - If burst_cnt < BURSTS_PER_LINE-1: increment burst_cnt and go to REQ.
  - Otherwise the line is complete: clear burst_cnt, set full[Fill_sel], toggle Fill_sel, increment line_cnt.
  - Then: if line_cnt was LINES-1, go to DONE. Else if full[new Fill_sel]=1, go to HOLD. Else go to REQ.
- HOLD: when full[Fill_sel] clears, go to REQ.
- Line_done, in any state except IDLE: if full[Disp_sel]=1, clear it; otherwise set Underflow. In both cases toggle Disp_sel.
- Simultaneous line completion and Line_done: both updates apply in the same cycle. A buffer freed by Line_done in the same cycle that the fill toggles onto it counts as free, so the next state is REQ, not HOLD.
- Frame_start while Frame_busy=1 sets restart_pend:
  - In REQ before Rd_ack, or in HOLD: restart on the next cycle. Rd_req drops for at least one cycle first.
  - In WAIT_DONE: restart on the Rd_done cycle. The address and full update for that burst are discarded.
  - On restart, Fb_base is sampled at restart time.
- Enable=0: go to IDLE next cycle, Rd_req=0, Underflow=0. Any outstanding burst's Rd_done is ignored.
- Rst mid-burst: all state returns to reset values immediately. The memory side must tolerate an abandoned burst.

## Timing
- Frame_start at cycle N (accepted) gives Rd_req=1 and Rd_addr=Fb_base at N+1.
- Rd_ack at cycle M gives Rd_req=0 at M+1.
- Rd_done at cycle D gives the next Rd_req=1 at D+1 with the incremented address, unless the next state is HOLD or DONE.
- A line completion at D updates Line_ready at D+1.
- Line_done at cycle L updates Disp_sel, Line_ready and Underflow at L+1.
- A combinational Rd_ack in the same cycle Rd_req rises is legal. The minimum burst turnaround is 2 cycles.

## Test plan
- Reset, then Enable=1 and Frame_start with Fb_base=0x1000_0000, immediate ack and Rd_done 4 cycles later → 20 bursts at 0x1000_0000..0x1000_1300; full[0]=1, Fill_sel=1, Line_ready=1.
- No Line_done after frame start → two lines fill, then HOLD with Rd_req=0. One Line_done → Disp_sel=1, request to 0x1000_2800 one cycle after HOLD exits.
- Line_done with Line_ready=0 → Underflow=1 and stays 1 until Enable=0.
- Frame_start during WAIT_DONE with Fb_base=0x2000_0000 → after Rd_done, Rd_req=1 at 0x2000_0000, line_cnt=0, full=0.
- Full frame with prompt Line_done → exactly 20480 bursts, final address 0x1050_0000 after the last increment, state DONE, Frame_busy=0. Line_done and the final line completion in the same cycle → no HOLD entry.
- Assert Rst during WAIT_DONE → all outputs return to reset values in the same cycle, and a later Rd_done is ignored.
